// File: rtl/edge_line_scheduler.sv
// Sequencer for the 3-line edge-threshold path: line-store writes, slot roles,
// convolution strobe and packed dx/dy result drain over a valid/ready port.
module edge_line_scheduler #(
   parameter int stripwidth  = 640,
   parameter int frame_lines = 480,
   parameter int DATA_W      = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_frame_start,
   input  logic                  i_pixel_valid,
   input  logic [DATA_W-1:0]     i_pixel,
   output logic                  o_buf_we,
   output logic [1:0]            o_buf_slot,
   output logic [9:0]            o_buf_addr,
   output logic [DATA_W-1:0]     o_buf_wdata,
   output logic [1:0]            o_up_slot,
   output logic [1:0]            o_mid_slot,
   output logic [1:0]            o_down_slot,
   output logic                  o_conv_update,
   input  logic [stripwidth-3:0] i_thdx_line,
   input  logic [stripwidth-3:0] i_thdy_line,
   output logic                  o_res_valid,
   input  logic                  i_res_ready,
   output logic [31:0]           o_res_data,
   output logic                  o_res_last,
   output logic                  o_res_frame_end,
   output logic                  o_overrun
);

   localparam int NCOL = stripwidth - 2;
   localparam int NW   = (NCOL + 15) / 16;
   localparam int PADW = 16 * NW;
   localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int LC_W = (frame_lines > 1) ? $clog2(frame_lines) : 1;

   localparam logic [9:0]      COL_LAST = 10'(stripwidth - 1);
   localparam logic [LC_W-1:0] LC_LAST  = LC_W'(frame_lines - 1);
   localparam logic [WC_W-1:0] WC_LAST  = WC_W'(NW - 1);
   localparam logic            SINGLE   = (NW == 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_CONV, S_DRAIN} state_t;

   function automatic logic [1:0] next3(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic logic [1:0] prev3(input logic [1:0] s);
      return (s == 2'd0) ? 2'd2 : s - 2'd1;
   endfunction

   function automatic logic [1:0] sat_inc3(input logic [1:0] s);
      return (s == 2'd3) ? 2'd3 : s + 2'd1;
   endfunction

   // Word k interleaves dx/dy of columns 1+16k .. 16+16k; padding bits read as 0.
   function automatic logic [31:0] pack_word(input logic [PADW-1:0] dx,
                                             input logic [PADW-1:0] dy,
                                             input logic [WC_W-1:0] k);
      logic [31:0] w;
      logic [15:0] sx;
      logic [15:0] sy;
      sx = dx[int'(k)*16 +: 16];
      sy = dy[int'(k)*16 +: 16];
      for (int j = 0; j < 16; j++) begin
         w[2*j]   = sx[j];
         w[2*j+1] = sy[j];
      end
      return w;
   endfunction

   state_t            r_state;
   logic [9:0]        r_col;
   logic [LC_W-1:0]   r_lcnt;
   logic [1:0]        r_lines_done;
   logic [1:0]        r_ws;
   logic [1:0]        r_up;
   logic [1:0]        r_mid;
   logic [1:0]        r_down;
   logic              r_skid_vld;
   logic [DATA_W-1:0] r_skid_pix;
   logic [9:0]        r_skid_col;
   logic              r_buf_we;
   logic [1:0]        r_buf_slot;
   logic [9:0]        r_buf_addr;
   logic [DATA_W-1:0] r_buf_wdata;
   logic              r_conv_update;
   logic [PADW-1:0]   r_thdx;
   logic [PADW-1:0]   r_thdy;
   logic [WC_W-1:0]   r_wcnt;
   logic              r_res_valid;
   logic [31:0]       r_res_data;
   logic              r_res_last;
   logic              r_res_fe;
   logic              r_fe_row;
   logic              r_overrun;

   logic              w_line_done;
   logic              w_have_two;
   logic              w_roll;
   logic              w_take;
   logic              w_skid_in;
   logic [9:0]        w_pix_col;
   logic [WC_W-1:0]   w_wnext;
   logic [PADW-1:0]   w_dx_pad;
   logic [PADW-1:0]   w_dy_pad;

   assign w_line_done = r_buf_we && (r_buf_addr == COL_LAST);
   assign w_have_two  = (r_lines_done >= 2'd2);
   assign w_roll      = w_line_done && !i_frame_start;
   assign w_take      = i_pixel_valid && (r_state != S_CONV);
   assign w_skid_in   = i_pixel_valid && (r_state == S_CONV);
   assign w_pix_col   = i_frame_start ? 10'd0 : r_col;
   assign w_wnext     = r_wcnt + 1'b1;
   assign w_dx_pad    = PADW'(i_thdx_line);
   assign w_dy_pad    = PADW'(i_thdy_line);

   // Write stage: direct pixels, or the skid entry held over from the CONV cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_buf_we    <= 1'b0;
         r_buf_slot  <= 2'd0;
         r_buf_addr  <= 10'd0;
         r_buf_wdata <= '0;
         r_skid_vld  <= 1'b0;
         r_skid_pix  <= '0;
         r_skid_col  <= 10'd0;
         r_col       <= 10'd0;
      end else begin
         r_buf_we <= w_take || r_skid_vld;
         if (r_skid_vld) begin
            r_buf_slot  <= r_ws;
            r_buf_addr  <= r_skid_col;
            r_buf_wdata <= r_skid_pix;
         end else if (w_take) begin
            r_buf_slot  <= i_frame_start ? 2'd0 : r_ws;
            r_buf_addr  <= w_pix_col;
            r_buf_wdata <= i_pixel;
         end
         r_skid_vld <= w_skid_in;
         if (w_skid_in) begin
            r_skid_pix <= i_pixel;
            r_skid_col <= w_pix_col;
         end
         if (i_frame_start)
            r_col <= i_pixel_valid ? 10'd1 : 10'd0;
         else if (i_pixel_valid)
            r_col <= (r_col == COL_LAST) ? 10'd0 : r_col + 10'd1;
      end
   end

   // Line bookkeeping: roles are assigned from the slot just finished (down).
   always_ff @(posedge i_clock) begin
      if (i_reset || i_frame_start) begin
         r_ws         <= 2'd0;
         r_lcnt       <= '0;
         r_lines_done <= 2'd0;
         r_up         <= 2'd0;
         r_mid        <= 2'd1;
         r_down       <= 2'd2;
      end else if (w_line_done) begin
         r_ws         <= next3(r_ws);
         r_lcnt       <= (r_lcnt == LC_LAST) ? r_lcnt : r_lcnt + 1'b1;
         r_lines_done <= sat_inc3(r_lines_done);
         if (w_have_two) begin
            r_up   <= next3(r_ws);
            r_mid  <= prev3(r_ws);
            r_down <= r_ws;
         end
      end
   end

   // Control FSM and result drain.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_conv_update <= 1'b0;
         r_thdx        <= '0;
         r_thdy        <= '0;
         r_wcnt        <= '0;
         r_res_valid   <= 1'b0;
         r_res_data    <= 32'd0;
         r_res_last    <= 1'b0;
         r_res_fe      <= 1'b0;
         r_fe_row      <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_conv_update <= 1'b0;
         if (w_roll && w_have_two && (r_state == S_DRAIN))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (i_frame_start)
                  r_state <= S_FILL;
            end
            S_FILL: begin
               if (w_roll && w_have_two) begin
                  r_state       <= S_CONV;
                  r_conv_update <= 1'b1;
                  r_fe_row      <= (r_lcnt == LC_LAST);
               end
            end
            S_CONV: begin
               r_thdx      <= w_dx_pad;
               r_thdy      <= w_dy_pad;
               r_wcnt      <= '0;
               r_res_valid <= 1'b1;
               r_res_data  <= pack_word(w_dx_pad, w_dy_pad, '0);
               r_res_last  <= SINGLE;
               r_res_fe    <= SINGLE && r_fe_row;
               r_state     <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_res_valid && i_res_ready) begin
                  if (r_wcnt == WC_LAST) begin
                     r_res_valid <= 1'b0;
                     r_res_last  <= 1'b0;
                     r_res_fe    <= 1'b0;
                     r_state     <= S_FILL;
                  end else begin
                     r_wcnt     <= w_wnext;
                     r_res_data <= pack_word(r_thdx, r_thdy, w_wnext);
                     r_res_last <= (w_wnext == WC_LAST);
                     r_res_fe   <= (w_wnext == WC_LAST) && r_fe_row;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_buf_we        = r_buf_we;
   assign o_buf_slot      = r_buf_slot;
   assign o_buf_addr      = r_buf_addr;
   assign o_buf_wdata     = r_buf_wdata;
   assign o_up_slot       = r_up;
   assign o_mid_slot      = r_mid;
   assign o_down_slot     = r_down;
   assign o_conv_update   = r_conv_update;
   assign o_res_valid     = r_res_valid;
   assign o_res_data      = r_res_data;
   assign o_res_last      = r_res_last;
   assign o_res_frame_end = r_res_fe;
   assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_edge_line_scheduler.sv
// Scoreboard bench for edge_line_scheduler on a reduced 40-pixel, 8-line geometry
// (38 result columns -> 3 words per row, last word with zero tail bits).
module tb_edge_line_scheduler;

   localparam int SW   = 40;
   localparam int FL   = 8;
   localparam int NCOL = SW - 2;
   localparam int NW   = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            fs  = 1'b0;
   logic            pv  = 1'b0;
   logic [7:0]      pix = 8'd0;
   logic [NCOL-1:0] thdx = '0;
   logic [NCOL-1:0] thdy = '0;
   logic            rdy = 1'b1;

   logic        buf_we;
   logic [1:0]  buf_slot;
   logic [9:0]  buf_addr;
   logic [7:0]  buf_wdata;
   logic [1:0]  up_slot, mid_slot, down_slot;
   logic        conv_update;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_last;
   logic        res_fe;
   logic        overrun;

   edge_line_scheduler #(.stripwidth(SW), .frame_lines(FL), .DATA_W(8)) dut (
      .i_clock(clk), .i_reset(rst), .i_frame_start(fs), .i_pixel_valid(pv), .i_pixel(pix),
      .o_buf_we(buf_we), .o_buf_slot(buf_slot), .o_buf_addr(buf_addr), .o_buf_wdata(buf_wdata),
      .o_up_slot(up_slot), .o_mid_slot(mid_slot), .o_down_slot(down_slot),
      .o_conv_update(conv_update), .i_thdx_line(thdx), .i_thdy_line(thdy),
      .o_res_valid(res_valid), .i_res_ready(rdy), .o_res_data(res_data),
      .o_res_last(res_last), .o_res_frame_end(res_fe), .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      logic        last;
      logic        fe;
   } word_t;
   typedef struct {
      logic [1:0] slot;
      logic [9:0] addr;
      logic [7:0] data;
      int         at;
   } wr_t;

   word_t sb[$];
   wr_t   wq[$];
   int checks = 0;
   int errors = 0;
   int bws = 0;
   int bcol = 0;
   int conv_cnt = 0;
   int last_wr_cyc = -10;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Hand-packed expectations for each threshold pattern.
   function automatic logic [31:0] exp_word(int pat, int k);
      case (pat)
         1: return (k == 0) ? 32'h0000_0002 : (k == 1) ? 32'h0000_0040 : 32'h0;
         2: return (k == 2) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
         3: return (k == 2) ? 32'h0000_0555 : 32'h5555_5555;
         4: return (k == 0) ? 32'h0 : (k == 1) ? 32'h0000_0002 : 32'h0000_0400;
         default: return 32'h0;
      endcase
   endfunction

   task automatic set_thd(int pat);
      thdx = '0;
      thdy = '0;
      case (pat)
         1: begin thdx[19] = 1'b1; thdy[0] = 1'b1; end
         2: begin thdx = '1; thdy = '1; end
         3: thdx = '1;
         4: begin thdx[37] = 1'b1; thdy[16] = 1'b1; end
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_line(input int base, input int step, input bit conv, input int pat,
                            input bit fe, input bit skid, input bit fsf, input int gap);
      repeat (gap) tick();
      for (int c = 0; c < SW; c++) begin
         logic [7:0] p;
         wr_t        e;
         word_t      w;
         p = 8'(base + c * step);
         if (c == 0 && fsf) begin
            fs   = 1'b1;
            bws  = 0;
            bcol = 0;
         end
         if (c == SW - 2) set_thd(pat);
         e.slot = 2'(bws);
         e.addr = 10'(bcol);
         e.data = p;
         e.at   = cyc + 1 + ((c == 0 && skid) ? 1 : 0);
         wq.push_back(e);
         bcol++;
         if (bcol == SW) begin
            bcol = 0;
            bws  = (bws + 1) % 3;
         end
         if (c == SW - 1 && conv) begin
            for (int k = 0; k < NW; k++) begin
               w.d    = exp_word(pat, k);
               w.last = (k == NW - 1);
               w.fe   = fe && (k == NW - 1);
               sb.push_back(w);
            end
         end
         pv  = 1'b1;
         pix = p;
         tick();
         pv = 1'b0;
         fs = 1'b0;
         tick();
      end
   endtask

   task automatic chk_roles(string name, int u, int m, int d);
      chk({name, "_up"},   32'(up_slot),   32'(u));
      chk({name, "_mid"},  32'(mid_slot),  32'(m));
      chk({name, "_down"}, 32'(down_slot), 32'(d));
   endtask

   // Monitors: line-store writes, conv strobe timing, result words.
   logic        held = 1'b0;
   logic [31:0] hd;
   logic        hl, hf;
   logic        prev_valid = 1'b0;
   logic        prev_conv  = 1'b0;

   always @(negedge clk) begin
      wr_t   e;
      word_t w;
      if (!rst && buf_we === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", 32'(buf_addr), 32'hFFFF_FFFF);
         end else begin
            e = wq.pop_front();
            chk("wr_slot",  32'(buf_slot),  32'(e.slot));
            chk("wr_addr",  32'(buf_addr),  32'(e.addr));
            chk("wr_data",  32'(buf_wdata), 32'(e.data));
            chk("wr_cycle", 32'(cyc),       32'(e.at));
         end
         if (buf_addr == 10'(SW - 1)) last_wr_cyc = cyc;
      end
      if (conv_update === 1'b1) begin
         conv_cnt++;
         chk("conv_timing", 32'(cyc), 32'(last_wr_cyc + 1));
      end
      if (res_valid === 1'b1) begin
         if (!prev_valid) chk("valid_after_conv", 32'(prev_conv), 32'd1);
         if (held) begin
            chk("stable_data", res_data, hd);
            chk("stable_last", 32'(res_last), 32'(hl));
            chk("stable_fe",   32'(res_fe),   32'(hf));
         end
         if (rdy) begin
            held = 1'b0;
            if (sb.size() == 0) begin
               chk("unexpected_word", res_data, 32'hDEAD_BEEF);
            end else begin
               w = sb.pop_front();
               chk("res_data",      res_data,         w.d);
               chk("res_last",      32'(res_last),    32'(w.last));
               chk("res_frame_end", 32'(res_fe),      32'(w.fe));
            end
         end else begin
            held = 1'b1;
            hd   = res_data;
            hl   = res_last;
            hf   = res_fe;
         end
      end else begin
         held = 1'b0;
      end
      prev_valid = (res_valid === 1'b1);
      prev_conv  = (conv_update === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_buf_we",  32'(buf_we), 0);
      chk_roles("rst", 0, 1, 2);
      chk("rst_conv",    32'(conv_update), 0);
      chk("rst_valid",   32'(res_valid), 0);
      chk("rst_data",    res_data, 0);
      chk("rst_last",    32'(res_last), 0);
      chk("rst_fe",      32'(res_fe), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      tick();

      // Frame 1: three flat lines, then a full frame with varied thresholds.
      fs = 1'b1; bws = 0; bcol = 0;
      tick();
      fs = 1'b0;
      tick();
      send_line(100, 0, 0, 0, 0, 0, 0, 0);
      send_line(100, 0, 0, 0, 0, 0, 0, 0);
      chk("no_conv_line1", 32'(conv_update), 0);
      send_line(100, 0, 1, 0, 0, 0, 0, 0);
      chk("conv_line2", 32'(conv_update), 1);
      chk_roles("line2", 0, 1, 2);
      send_line(10, 3, 1, 1, 0, 1, 0, 0);
      chk_roles("line3", 1, 2, 0);
      chk("overrun_f1", 32'(overrun), 0);
      send_line(7, 5, 1, 2, 0, 1, 0, 0);
      send_line(200, 1, 1, 3, 0, 1, 0, 0);
      chk_roles("line5", 0, 1, 2);
      send_line(33, 7, 1, 4, 0, 1, 0, 0);
      send_line(90, 2, 1, 1, 1, 1, 0, 0);

      // Frame 2: frame_start with a pixel in the CONV cycle, then a stalled row.
      send_line(50, 1, 0, 0, 0, 1, 1, 0);
      chk("conv_count_f1", 32'(conv_cnt), 6);
      send_line(60, 1, 0, 0, 0, 0, 0, 0);
      rdy = 1'b0;
      send_line(70, 1, 1, 2, 0, 0, 0, 0);
      send_line(80, 1, 0, 0, 0, 1, 0, 0);
      chk("skipped_conv", 32'(conv_update), 0);
      chk("overrun_set", 32'(overrun), 1);
      chk("stall_valid", 32'(res_valid), 1);
      chk_roles("ovr_line3", 1, 2, 0);
      rdy = 1'b1;
      send_line(90, 1, 1, 3, 0, 0, 0, 0);
      chk("conv_after_ovr", 32'(conv_update), 1);

      // Frame 3: frame_start (with column 0) lands while the row drains.
      send_line(20, 2, 0, 0, 0, 0, 1, 1);
      send_line(30, 2, 0, 0, 0, 0, 0, 0);
      chk("conv_count_fs", 32'(conv_cnt), 8);
      chk("overrun_sticky", 32'(overrun), 1);
      send_line(40, 2, 1, 4, 0, 0, 0, 0);
      repeat (6) tick();
      rdy = 1'b0;
      send_line(15, 4, 0, 1, 0, 0, 0, 0);
      repeat (3) tick();
      chk("pre_reset_valid", 32'(res_valid), 1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_reset_valid", 32'(res_valid), 0);
      chk("post_reset_overrun", 32'(overrun), 0);
      chk("post_reset_conv", 32'(conv_update), 0);
      chk_roles("post_reset", 0, 1, 2);
      rdy = 1'b1;
      repeat (6) tick();
      chk("post_reset_idle_valid", 32'(res_valid), 0);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("wq_drained", 32'(wq.size()), 0);
      chk("conv_count_total", 32'(conv_cnt), 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
